// File: rtl/hpm_pkg.sv
// Shared definitions for the hardware performance monitor bank.
// Holds the CSR address bases, Sscofpmf flag bit positions, the event
// register layout and small helpers used by the bank and its counters.
package hpm_pkg;

    localparam int unsigned CNT_W     = 64;
    localparam int unsigned SEL_W     = 8;
    localparam int unsigned FIRST_HPM = 3;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENTH    = 12'h720;

    // Flag positions in the RV64 mhpmevent view
    localparam int unsigned OF_BIT   = 63;
    localparam int unsigned MINH_BIT = 62;
    localparam int unsigned SINH_BIT = 61;
    localparam int unsigned UINH_BIT = 60;
    // Same flags in the RV32 mhpmeventh view
    localparam int unsigned OFH_BIT   = 31;
    localparam int unsigned UINHH_BIT = 28;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    typedef struct packed {
        logic             of;
        logic             minh;
        logic             sinh;
        logic             uinh;
        logic [SEL_W-1:0] sel;
    } hpm_event_t;

    // Event selects at or above the implemented event count are illegal
    function automatic logic sel_legal(logic [SEL_W-1:0] sel, int unsigned num_events);
        return 32'(sel) < num_events;
    endfunction

    // Writable mcountinhibit bits: CY, IR and the implemented hpm counters
    function automatic logic [31:0] inhibit_mask(int unsigned num_hpm);
        return 32'h5 | (((32'd1 << num_hpm) - 32'd1) << FIRST_HPM);
    endfunction

    // Next counter value: a write to a half wins over the increment of that half
    function automatic logic [CNT_W-1:0] cnt_next(logic [CNT_W-1:0] cnt, logic inc,
                                                 logic wr_lo, logic wr_hi,
                                                 logic [CNT_W-1:0] wval, logic rv64);
        logic [CNT_W-1:0] sum;
        logic [CNT_W-1:0] res;
        sum = cnt + CNT_W'(inc);
        res = sum;
        if (wr_lo && rv64) begin
            res = wval;
        end else if (wr_lo) begin
            res = {cnt[63:32], wval[31:0]};
        end else if (wr_hi) begin
            res = {wval[31:0], sum[31:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/csr_hpm_bank_if.sv
// CSR access and event bus between the machine CSR block and the HPM bank.
// master: CSR block side (drives address/write/events, receives read data).
// slave : HPM bank side.
interface csr_hpm_bank_if #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned NUM_EVENTS = 16
) ();
    logic                  CSRWriteM;
    logic [11:0]           CSRAdrM;
    logic [XLEN-1:0]       CSRWriteValM;
    logic [NUM_EVENTS-1:0] EventsM;
    logic [1:0]            PrivilegeModeM;
    logic [XLEN-1:0]       ReadValM;
    logic                  AdrHitM;
    logic [31:0]           MCOUNTINHIBIT_REGW;
    logic [31:0]           SCOUNTOVF_REGW;
    logic                  LCOFIPulseM;

    modport master (
        output CSRWriteM, CSRAdrM, CSRWriteValM, EventsM, PrivilegeModeM,
        input  ReadValM, AdrHitM, MCOUNTINHIBIT_REGW, SCOUNTOVF_REGW, LCOFIPulseM
    );

    modport slave (
        input  CSRWriteM, CSRAdrM, CSRWriteValM, EventsM, PrivilegeModeM,
        output ReadValM, AdrHitM, MCOUNTINHIBIT_REGW, SCOUNTOVF_REGW, LCOFIPulseM
    );
endinterface

// File: rtl/hpm_counter.sv
// One programmable mhpmcounter with its mhpmevent register, privilege
// filter and overflow detection.
// Ports: clk/reset; cnt_wr_lo_i/cnt_wr_hi_i counter half writes;
// evt_wr_lo_i/evt_wr_hi_i event register writes (hi only used in RV32);
// wval_i zero-extended write data; events_i event pulses; priv_i mode;
// inhibit_i mcountinhibit bit; count_o/event_o state; of_set_c hardware OF set.
module hpm_counter
    import hpm_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned NUM_EVENTS = 16,
    parameter bit          SSCOFPMF   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cnt_wr_lo_i,
    input  logic                  cnt_wr_hi_i,
    input  logic                  evt_wr_lo_i,
    input  logic                  evt_wr_hi_i,
    input  logic [CNT_W-1:0]      wval_i,
    input  logic [NUM_EVENTS-1:0] events_i,
    input  logic [1:0]            priv_i,
    input  logic                  inhibit_i,
    output logic [CNT_W-1:0]      count_o,
    output hpm_event_t            event_o,
    output logic                  of_set_c
);
    localparam bit RV64 = (XLEN == 64);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    hpm_event_t       evt_q, evt_d;
    logic             ev_hit_c, filtered_c, inc_c, wrap_c, flag_wr_c;
    logic [3:0]       flag_val_c;

    // Event match, mode filter, increment and overflow
    always_comb begin
        ev_hit_c   = 1'b0;
        filtered_c = 1'b0;
        ev_hit_c   = (evt_q.sel != '0) &&
                     ((events_i & (NUM_EVENTS'(1) << evt_q.sel)) != '0);
        case (priv_i)
            PRIV_M:  filtered_c = evt_q.minh;
            PRIV_S:  filtered_c = evt_q.sinh;
            PRIV_U:  filtered_c = evt_q.uinh;
            default: filtered_c = 1'b0;
        endcase
        inc_c  = !inhibit_i && ev_hit_c && !filtered_c;
        cnt_d  = cnt_next(cnt_q, inc_c, cnt_wr_lo_i, cnt_wr_hi_i, wval_i, RV64);
        wrap_c = inc_c && !cnt_wr_lo_i && !cnt_wr_hi_i && (cnt_q == '1);

        // RV64 carries the flags in mhpmevent itself, RV32 in mhpmeventh
        flag_wr_c  = RV64 ? evt_wr_lo_i : evt_wr_hi_i;
        flag_val_c = RV64 ? wval_i[OF_BIT:UINH_BIT] : wval_i[OFH_BIT:UINHH_BIT];
        of_set_c   = SSCOFPMF && wrap_c && !evt_q.of && !flag_wr_c;

        evt_d = evt_q;
        if (evt_wr_lo_i) begin
            evt_d.sel = sel_legal(wval_i[SEL_W-1:0], NUM_EVENTS) ? wval_i[SEL_W-1:0] : '0;
        end
        if (flag_wr_c) begin
            {evt_d.of, evt_d.minh, evt_d.sinh, evt_d.uinh} = flag_val_c;
        end else if (of_set_c) begin
            evt_d.of = 1'b1;
        end
        if (!SSCOFPMF) begin
            {evt_d.of, evt_d.minh, evt_d.sinh, evt_d.uinh} = 4'b0;
        end
    end

    // Counter and event register state
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            evt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign count_o = cnt_q;
    assign event_o = evt_q;

endmodule

// File: rtl/csr_hpm_bank.sv
// Machine-mode performance monitor bank: mcycle, minstret, NUM_HPM
// programmable counters, mcountinhibit and Sscofpmf overflow interrupt.
// Ports: clk, reset (sync, active-high); bus (slave) carries CSRWriteM,
// CSRAdrM, CSRWriteValM, EventsM, PrivilegeModeM in and ReadValM, AdrHitM,
// MCOUNTINHIBIT_REGW, SCOUNTOVF_REGW, LCOFIPulseM out.
module csr_hpm_bank
    import hpm_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned NUM_HPM    = 4,
    parameter int unsigned NUM_EVENTS = 16,
    parameter bit          SSCOFPMF   = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    csr_hpm_bank_if.slave bus
);
    localparam bit          RV64     = (XLEN == 64);
    localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

    logic [11:0]             adr_c;
    logic [4:0]              idx_c;
    logic                    is_cnt_c, is_cnth_c, is_evt_c, is_evth_c, wr_c;
    logic [CNT_W-1:0]        wval_c, rd_c;
    hpm_event_t              ev_c;
    logic [31:0]             ovf_c;
    logic [31:0][CNT_W-1:0]  cnt_all;
    hpm_event_t [31:0]       evt_all;
    logic [31:0]             of_set_c;

    logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [31:0]      inh_q, inh_d;
    logic             lcofi_q, lcofi_d;

    // Address decode, read mux and next state of the inline registers
    always_comb begin
        adr_c  = bus.CSRAdrM;
        idx_c  = adr_c[4:0];
        wval_c = CNT_W'(bus.CSRWriteValM);
        // Index 1 (time) is not ours; unimplemented hpm slots still hit
        is_cnt_c  = (adr_c[11:5] == CSR_MCYCLE[11:5]) && (idx_c != 5'd1);
        is_cnth_c = !RV64 && (adr_c[11:5] == CSR_MCYCLEH[11:5]) && (idx_c != 5'd1);
        is_evt_c  = (adr_c[11:5] == CSR_MCOUNTINHIBIT[11:5]) &&
                    ((idx_c == 5'd0) || (idx_c >= 5'(FIRST_HPM)));
        is_evth_c = !RV64 && (adr_c[11:5] == CSR_MHPMEVENTH[11:5]) &&
                    (idx_c >= 5'(FIRST_HPM));
        wr_c = bus.CSRWriteM && (is_cnt_c || is_cnth_c || is_evt_c || is_evth_c);

        ev_c = evt_all[idx_c];
        rd_c = '0;
        if (is_cnt_c) begin
            rd_c = RV64 ? cnt_all[idx_c] : CNT_W'(cnt_all[idx_c][31:0]);
        end else if (is_cnth_c) begin
            rd_c = CNT_W'(cnt_all[idx_c][63:32]);
        end else if (is_evt_c) begin
            if (idx_c == 5'd0) begin
                rd_c = CNT_W'(inh_q);
            end else if (RV64) begin
                rd_c = {ev_c.of, ev_c.minh, ev_c.sinh, ev_c.uinh, 52'b0, ev_c.sel};
            end else begin
                rd_c = CNT_W'(ev_c.sel);
            end
        end else if (is_evth_c) begin
            rd_c = CNT_W'({ev_c.of, ev_c.minh, ev_c.sinh, ev_c.uinh, 28'b0});
        end

        mcycle_d   = cnt_next(mcycle_q, !inh_q[0],
                              wr_c && is_cnt_c && (idx_c == 5'd0),
                              wr_c && is_cnth_c && (idx_c == 5'd0), wval_c, RV64);
        minstret_d = cnt_next(minstret_q, bus.EventsM[0] && !inh_q[2],
                              wr_c && is_cnt_c && (idx_c == 5'd2),
                              wr_c && is_cnth_c && (idx_c == 5'd2), wval_c, RV64);
        inh_d      = (wr_c && is_evt_c && (idx_c == 5'd0)) ? (wval_c[31:0] & INH_MASK) : inh_q;
        // Several counters wrapping together still give a single pulse
        lcofi_d    = |of_set_c;

        ovf_c = '0;
        for (int i = 0; i < 32; i++) begin
            ovf_c[i] = evt_all[i].of;
        end
    end

    // Inline counter, inhibit and interrupt pulse state
    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            inh_q      <= '0;
            lcofi_q    <= 1'b0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            inh_q      <= inh_d;
            lcofi_q    <= lcofi_d;
        end
    end

    // One slot per counter index; fixed slots expose mcycle/minstret or zero
    for (genvar g = 0; g < 32; g++) begin : g_slot
        if (g >= FIRST_HPM && g < FIRST_HPM + NUM_HPM) begin : g_hpm
            hpm_counter #(
                .XLEN       (XLEN),
                .NUM_EVENTS (NUM_EVENTS),
                .SSCOFPMF   (SSCOFPMF)
            ) u_cnt (
                .clk         (clk),
                .reset       (reset),
                .cnt_wr_lo_i (wr_c && is_cnt_c && (idx_c == 5'(g))),
                .cnt_wr_hi_i (wr_c && is_cnth_c && (idx_c == 5'(g))),
                .evt_wr_lo_i (wr_c && is_evt_c && (idx_c == 5'(g))),
                .evt_wr_hi_i (wr_c && is_evth_c && (idx_c == 5'(g))),
                .wval_i      (wval_c),
                .events_i    (bus.EventsM),
                .priv_i      (bus.PrivilegeModeM),
                .inhibit_i   (inh_q[g]),
                .count_o     (cnt_all[g]),
                .event_o     (evt_all[g]),
                .of_set_c    (of_set_c[g])
            );
        end else begin : g_fixed
            assign cnt_all[g]  = (g == 0) ? mcycle_q : ((g == 2) ? minstret_q : '0);
            assign evt_all[g]  = '0;
            assign of_set_c[g] = 1'b0;
        end
    end

    assign bus.ReadValM           = XLEN'(rd_c);
    assign bus.AdrHitM            = is_cnt_c || is_cnth_c || is_evt_c || is_evth_c;
    assign bus.MCOUNTINHIBIT_REGW = inh_q;
    assign bus.SCOUNTOVF_REGW     = ovf_c;
    assign bus.LCOFIPulseM        = lcofi_q;

endmodule

// File: tb/tb_csr_hpm_bank.sv
// Directed bench for csr_hpm_bank: one RV64 and one RV32 instance sharing
// clock and reset; inputs change on the falling edge, outputs are checked
// shortly after it.
module tb_csr_hpm_bank;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    csr_hpm_bank_if #(.XLEN(64), .NUM_EVENTS(16)) if64 ();
    csr_hpm_bank_if #(.XLEN(32), .NUM_EVENTS(16)) if32 ();

    csr_hpm_bank #(.XLEN(64), .NUM_HPM(4), .NUM_EVENTS(16), .SSCOFPMF(1'b1)) u_dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (if64)
    );

    csr_hpm_bank #(.XLEN(32), .NUM_HPM(4), .NUM_EVENTS(16), .SSCOFPMF(1'b1)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (if32)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(negedge clk);
    endtask

    task automatic wr64(input logic [11:0] adr, input logic [63:0] val);
        if64.CSRWriteM    = 1'b1;
        if64.CSRAdrM      = adr;
        if64.CSRWriteValM = val;
        @(negedge clk);
        if64.CSRWriteM    = 1'b0;
    endtask

    task automatic wr32(input logic [11:0] adr, input logic [31:0] val);
        if32.CSRWriteM    = 1'b1;
        if32.CSRAdrM      = adr;
        if32.CSRWriteValM = val;
        @(negedge clk);
        if32.CSRWriteM    = 1'b0;
    endtask

    task automatic rd64(input string tag, input logic [11:0] adr, input logic [63:0] exp);
        if64.CSRAdrM = adr;
        #1;
        check_eq(tag, if64.ReadValM, exp);
    endtask

    task automatic rd32(input string tag, input logic [11:0] adr, input logic [31:0] exp);
        if32.CSRAdrM = adr;
        #1;
        check_eq(tag, 64'(if32.ReadValM), 64'(exp));
    endtask

    task automatic hit64(input string tag, input logic [11:0] adr, input logic exp);
        if64.CSRAdrM = adr;
        #1;
        check_eq(tag, 64'(if64.AdrHitM), 64'(exp));
    endtask

    task automatic hit32(input string tag, input logic [11:0] adr, input logic exp);
        if32.CSRAdrM = adr;
        #1;
        check_eq(tag, 64'(if32.AdrHitM), 64'(exp));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        if64.CSRWriteM = 1'b0; if64.CSRAdrM = 12'h0; if64.CSRWriteValM = '0;
        if64.EventsM = '0; if64.PrivilegeModeM = 2'b11;
        if32.CSRWriteM = 1'b0; if32.CSRAdrM = 12'h0; if32.CSRWriteValM = '0;
        if32.EventsM = '0; if32.PrivilegeModeM = 2'b11;

        // Reset state
        repeat (2) @(negedge clk);
        rd64("rst_mcycle", 12'hB00, 64'd0);
        check_eq("rst_lcofi", 64'(if64.LCOFIPulseM), 64'd0);
        check_eq("rst_inhibit", 64'(if64.MCOUNTINHIBIT_REGW), 64'd0);
        check_eq("rst_scountovf", 64'(if64.SCOUNTOVF_REGW), 64'd0);
        reset = 1'b0;

        // Ten free-running cycles
        repeat (10) @(posedge clk);
        sync();
        rd64("mcycle_10", 12'hB00, 64'd10);
        rd32("mcycle32_10", 12'hB00, 32'd10);
        rd64("minstret_0", 12'hB02, 64'd0);
        rd64("hpm3_0", 12'hB03, 64'd0);
        rd32("mcycleh32_0", 12'hB80, 32'd0);

        // Event 5 counted seven times in M-mode, instret alongside
        sync();
        wr64(12'h323, 64'd5);
        rd64("evt3_sel", 12'h323, 64'd5);
        sync();
        if64.EventsM = 16'h0021;
        repeat (7) @(negedge clk);
        if64.EventsM = '0;
        rd64("hpm3_7", 12'hB03, 64'd7);
        rd64("minstret_7", 12'hB02, 64'd7);

        // MINH stops counting in M-mode but not in U-mode
        sync();
        wr64(12'h323, 64'h4000_0000_0000_0005);
        if64.EventsM = 16'h0020;
        repeat (5) @(negedge clk);
        if64.EventsM = '0;
        rd64("hpm3_minh", 12'hB03, 64'd7);
        rd64("evt3_minh", 12'h323, 64'h4000_0000_0000_0005);
        sync();
        if64.PrivilegeModeM = 2'b00;
        if64.EventsM = 16'h0020;
        repeat (3) @(negedge clk);
        if64.EventsM = '0;
        if64.PrivilegeModeM = 2'b11;
        rd64("hpm3_umode", 12'hB03, 64'd10);

        // Overflow from all-ones sets OF and gives one pulse
        sync();
        wr64(12'h323, 64'd5);
        wr64(12'hB03, 64'hFFFF_FFFF_FFFF_FFFE);
        if64.EventsM = 16'h0020;
        @(negedge clk);
        check_eq("lcofi_pre", 64'(if64.LCOFIPulseM), 64'd0);
        rd64("hpm3_ones", 12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        if64.EventsM = '0;
        check_eq("lcofi_pulse", 64'(if64.LCOFIPulseM), 64'd1);
        rd64("hpm3_wrap", 12'hB03, 64'd0);
        rd64("evt3_of", 12'h323, 64'h8000_0000_0000_0005);
        check_eq("scountovf_3", 64'(if64.SCOUNTOVF_REGW), 64'h8);
        @(negedge clk);
        check_eq("lcofi_once", 64'(if64.LCOFIPulseM), 64'd0);

        // Second wrap with OF already set: no pulse
        wr64(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
        if64.EventsM = 16'h0020;
        @(negedge clk);
        if64.EventsM = '0;
        check_eq("lcofi_rewrap", 64'(if64.LCOFIPulseM), 64'd0);
        rd64("hpm3_rewrap", 12'hB03, 64'd0);
        check_eq("scountovf_keep", 64'(if64.SCOUNTOVF_REGW), 64'h8);

        // Software clearing OF in the wrap cycle beats the hardware set
        sync();
        wr64(12'h323, 64'd5);
        check_eq("scountovf_clr", 64'(if64.SCOUNTOVF_REGW), 64'h0);
        wr64(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
        if64.EventsM = 16'h0020;
        wr64(12'h323, 64'd5);
        if64.EventsM = '0;
        check_eq("lcofi_swwin", 64'(if64.LCOFIPulseM), 64'd0);
        check_eq("scountovf_swwin", 64'(if64.SCOUNTOVF_REGW), 64'h0);
        rd64("hpm3_swwin", 12'hB03, 64'd0);

        // Write in a cycle with an active event: value exact, no +1
        sync();
        if64.EventsM = 16'h0020;
        wr64(12'hB03, 64'h100);
        rd64("hpm3_wrwin", 12'hB03, 64'h100);
        if64.EventsM = '0;

        // mcountinhibit is WARL and freezes counters
        sync();
        wr64(12'h320, 64'hFFFF_FFFF);
        rd64("inhibit_rd", 12'h320, 64'h7D);
        check_eq("inhibit_regw", 64'(if64.MCOUNTINHIBIT_REGW), 64'h7D);
        sync();
        if64.EventsM = 16'h0021;
        repeat (3) @(negedge clk);
        if64.EventsM = '0;
        rd64("hpm3_inh", 12'hB03, 64'h100);
        rd64("minstret_inh", 12'hB02, 64'd7);
        sync();
        wr64(12'h320, 64'd0);

        // Illegal select, unimplemented slots and RV64 misses
        wr64(12'h323, 64'd200);
        rd64("evt3_warl", 12'h323, 64'd0);
        hit64("hit_330", 12'h330, 1'b1);
        sync();
        wr64(12'h330, 64'd5);
        rd64("rd_330", 12'h330, 64'd0);
        hit64("hit_b06", 12'hB06, 1'b1);
        rd64("rd_b07", 12'hB07, 64'd0);
        hit64("miss_321", 12'h321, 1'b0);
        hit64("miss_b01", 12'hB01, 1'b0);
        hit64("miss_b83_rv64", 12'hB83, 1'b0);
        hit64("miss_723_rv64", 12'h723, 1'b0);
        rd64("rd_miss", 12'hB83, 64'd0);

        // RV32 half writes compose a 64-bit counter
        sync();
        wr32(12'hB83, 32'h1);
        wr32(12'hB03, 32'h2);
        rd32("rv32_lo", 12'hB03, 32'h2);
        rd32("rv32_hi", 12'hB83, 32'h1);
        hit32("rv32_hit_b83", 12'hB83, 1'b1);
        hit32("rv32_hit_723", 12'h723, 1'b1);
        sync();
        wr32(12'h723, 32'h4000_0000);
        rd32("rv32_evth", 12'h723, 32'h4000_0000);
        rd32("rv32_evt_lo", 12'h323, 32'h0);
        sync();
        wr32(12'h323, 32'd5);
        rd32("rv32_evt_sel", 12'h323, 32'd5);
        rd32("rv32_evth_keep", 12'h723, 32'h4000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
